vram_write_port: RTL



---
 rtl/vram_write_port.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_write_port.sv
// vram_write_port
// CPU-side access port for the six 8-bit video RAM planes (fg1..3, bg1..3).
// Memory writes in the VRAM window are queued in a small FIFO. The FIFO is
// drained into the plane RAMs only in cycles the display generator does not
// own. Reads come from one selected plane. A read first drains all queued
// writes, so it always sees earlier writes.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   cpu_addr        CPU address (also carries the I/O port number in [7:0])
//   cpu_dout        CPU write data
//   mem_wr, mem_rd  single-cycle memory write / read strobes
//   io_wr           single-cycle I/O write strobe (F1h = rbank, F2h = wmask)
//   cpu_din         read data, qualified by cpu_rd_valid
//   cpu_rd_valid    one-cycle read-data pulse
//   cpu_wait        CPU must hold off new strobes while high
//   vdp_busy        display generator owns the VRAM port next cycle
//   vram_addr       plane address (cpu_addr - BASE)
//   vram_wdata      plane write data
//   vram_we         per-plane write enables, bit0..2 fg1..3, bit3..5 bg1..3
//   vram_re         read strobe
//   vram_rdata      all six planes, plane i on [8i+7:8i], valid after vram_re
module vram_write_port #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BASE       = 16'hEC00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        mem_wr,
    input  logic        mem_rd,
    input  logic        io_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rd_valid,
    output logic        cpu_wait,
    input  logic        vdp_busy,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic [5:0]  vram_we,
    output logic        vram_re,
    input  logic [47:0] vram_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
        logic [5:0]  mask;
    } wr_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DRAIN = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } rd_state_t;

    // state
    rd_state_t   state_q, state_d;
    logic [5:0]  wmask_q, wmask_d;
    logic [2:0]  rbank_q, rbank_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic        pend_vld_q, pend_vld_d;
    wr_entry_t   pend_q, pend_d;
    logic [12:0] rd_addr_q, rd_addr_d;
    wr_entry_t   fifo_q [FIFO_DEPTH];

    // registered outputs
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic        cpu_rd_valid_q, cpu_rd_valid_d;
    logic        cpu_wait_q, cpu_wait_d;
    logic [12:0] vram_addr_q, vram_addr_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;
    logic [5:0]  vram_we_q, vram_we_d;
    logic        vram_re_q, vram_re_d;

    // decode
    logic        in_win, wr_hit, rd_hit;
    logic [12:0] addr13;
    wr_entry_t   new_entry, push_entry, head;
    logic        pop, push, room, drained;
    logic [7:0]  rd_byte;

    assign in_win = (cpu_addr >= BASE);
    // The window is under 8K, so the low 13 bits of the difference are exact.
    assign addr13 = cpu_addr[12:0] - BASE[12:0];
    // Uses the wmask value from before this edge, so a same-cycle F2h write
    // only affects later stores.
    assign wr_hit = mem_wr && in_win && (wmask_q != 6'd0);
    assign rd_hit = mem_rd && in_win;

    assign new_entry  = '{addr: addr13, data: cpu_dout, mask: wmask_q};
    assign head       = fifo_q[rd_ptr_q];
    // The pending entry is older than any new strobe, so it goes first.
    assign push_entry = pend_vld_q ? pend_q : new_entry;

    assign pop     = (count_q != '0) && !vdp_busy && (state_q != RD_ISSUE);
    assign room    = (count_q != DEPTH_C) || pop;
    assign push    = (pend_vld_q || wr_hit) && room;
    assign drained = (count_q == '0) && !pend_vld_q;

    always_comb begin
        rd_byte = 8'hFF;
        case (rbank_q)
            3'd1: rd_byte = vram_rdata[7:0];
            3'd2: rd_byte = vram_rdata[15:8];
            3'd3: rd_byte = vram_rdata[23:16];
            3'd4: rd_byte = vram_rdata[31:24];
            3'd5: rd_byte = vram_rdata[39:32];
            3'd6: rd_byte = vram_rdata[47:40];
            default: rd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        wmask_d        = wmask_q;
        rbank_d        = rbank_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        pend_vld_d     = pend_vld_q;
        pend_d         = pend_q;
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        cpu_din_d      = cpu_din_q;
        cpu_rd_valid_d = 1'b0;
        vram_addr_d    = vram_addr_q;
        vram_wdata_d   = vram_wdata_q;
        vram_we_d      = 6'd0;
        vram_re_d      = 1'b0;

        if (io_wr && cpu_addr[7:0] == 8'hF2) wmask_d = cpu_dout[5:0];
        if (io_wr && cpu_addr[7:0] == 8'hF1) rbank_d = cpu_dout[2:0];

        // write buffer
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            vram_we_d    = head.mask;
            vram_addr_d  = head.addr;
            vram_wdata_d = head.data;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A pending entry leaves as soon as there is room. A write with no
        // room and no pending entry parks in the pending slot. A strobe that
        // arrives while the slot is already full breaks the wait protocol
        // and is dropped.
        if (pend_vld_q) begin
            pend_vld_d = !room;
        end else if (wr_hit && !room) begin
            pend_vld_d = 1'b1;
            pend_d     = new_entry;
        end

        // read sequencer
        case (state_q)
            IDLE: begin
                if (rd_hit) begin
                    state_d   = RD_DRAIN;
                    rd_addr_d = addr13;
                end
            end
            RD_DRAIN: begin
                // Once drained, issue right away when the port is free.
                // RD_ISSUE is only entered while the display owns the port.
                if (drained) begin
                    if (!vdp_busy) begin
                        vram_re_d   = 1'b1;
                        vram_addr_d = rd_addr_q;
                        state_d     = RD_DATA;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (!vdp_busy) begin
                    vram_re_d   = 1'b1;
                    vram_addr_d = rd_addr_q;
                    state_d     = RD_DATA;
                end
            end
            RD_DATA: begin
                // First cycle: vram_re is out. Second cycle: the data is valid.
                if (!vram_re_q) begin
                    cpu_din_d      = rd_byte;
                    cpu_rd_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_wait_d = pend_vld_d || (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wmask_q        <= '0;
            rbank_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pend_vld_q     <= 1'b0;
            pend_q         <= '0;
            rd_addr_q      <= '0;
            cpu_din_q      <= '0;
            cpu_rd_valid_q <= 1'b0;
            cpu_wait_q     <= 1'b0;
            vram_addr_q    <= '0;
            vram_wdata_q   <= '0;
            vram_we_q      <= '0;
            vram_re_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wmask_q        <= wmask_d;
            rbank_q        <= rbank_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pend_vld_q     <= pend_vld_d;
            pend_q         <= pend_d;
            rd_addr_q      <= rd_addr_d;
            cpu_din_q      <= cpu_din_d;
            cpu_rd_valid_q <= cpu_rd_valid_d;
            cpu_wait_q     <= cpu_wait_d;
            vram_addr_q    <= vram_addr_d;
            vram_wdata_q   <= vram_wdata_d;
            vram_we_q      <= vram_we_d;
            vram_re_q      <= vram_re_d;
        end
    end

    // Storage is not reset. Resetting the pointers and count empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign cpu_din      = cpu_din_q;
    assign cpu_rd_valid = cpu_rd_valid_q;
    assign cpu_wait     = cpu_wait_q;
    assign vram_addr    = vram_addr_q;
    assign vram_wdata   = vram_wdata_q;
    assign vram_we      = vram_we_q;
    assign vram_re      = vram_re_q;

endmodule
